// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait FSM with watchdog plus freeze/flush priority.
// Optional perf counters (stall/flush/mem-wait, saturating) are built when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  output logic             freeze_front,
  output logic             freeze_all,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             timeout_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [CNT_W-1:0] LP_WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;
  logic             w_mem_req;
  logic             w_freeze_all;

  assign w_mem_req = mem_r_en | mem_w_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_timeout_err_nxt = r_timeout_err;
    w_freeze_all      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_req && !sram_ready) begin
          w_freeze_all   = 1'b1;
          w_wait_cnt_nxt = CNT_W'(1);
          w_state_nxt    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        w_freeze_all = !sram_ready;
        // A request withdrawn without completion is an abort, not a timeout.
        if (sram_ready || !w_mem_req) begin
          w_wait_cnt_nxt = '0;
          w_state_nxt    = RUN;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = HALT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      HALT: begin
        w_freeze_all = 1'b1;
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // freeze_all masks branch and hazard; the frozen instructions are reapplied on release.
  assign freeze_all   = !rst && w_freeze_all;
  assign flush_if_id  = !rst && !w_freeze_all && branch_taken;
  assign flush_id_exe = !rst && !w_freeze_all && (branch_taken || hazard_detected);
  assign freeze_front = !rst && !w_freeze_all && !branch_taken && hazard_detected;
  assign timeout_err  = !rst && r_timeout_err;

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_mem_wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
      r_mem_wait_cnt <= '0;
    end else begin
      r_stall_cnt    <= sat_inc(r_stall_cnt, freeze_front || freeze_all);
      r_flush_cnt    <= sat_inc(r_flush_cnt, flush_if_id);
      r_mem_wait_cnt <= sat_inc(r_mem_wait_cnt, r_state == MEM_WAIT);
    end
  end

  assign stall_cnt    = rst ? '0 : r_stall_cnt;
  assign flush_cnt    = rst ? '0 : r_flush_cnt;
  assign mem_wait_cnt = rst ? '0 : r_mem_wait_cnt;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized self-checking bench for pipeline_stall_controller against a behavioural model,
// with directed literal checks for reset, priority, memory wait, timeout and saturation.
module tb_pipeline_stall_controller;
  localparam int TO = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_detected = 1'b1, branch_taken = 1'b1;
  logic mem_r_en = 1'b1, mem_w_en = 1'b1, sram_ready = 1'b1;
  logic freeze_front, freeze_all, flush_if_id, flush_id_exe, timeout_err;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt, mem_wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_ready(sram_ready),
    .freeze_front(freeze_front), .freeze_all(freeze_all), .flush_if_id(flush_if_id),
    .flush_id_exe(flush_id_exe), .timeout_err(timeout_err)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_wait_cnt(mem_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: n = consecutive frozen memory cycles so far (0 = no wait pending).
  int m_n = 0;
  bit m_halt = 0;
  int m_stall = 0, m_flush = 0, m_mw = 0;
  localparam int SAT = (1 << CW) - 1;

  always @(negedge clk) begin : compare
    bit req, efa, eff, efi, efe, eerr;
    req = mem_r_en | mem_w_en;
    efa = 0; eff = 0; efi = 0; efe = 0; eerr = 0;
    if (!rst) begin
      if (m_halt) begin
        efa = 1; eerr = 1;
      end else begin
        efa = (m_n == 0) ? (req && !sram_ready) : !sram_ready;
      end
      if (!efa) begin
        if (branch_taken) begin efi = 1; efe = 1; end
        else if (hazard_detected) begin eff = 1; efe = 1; end
      end
    end
    chk("m_freeze_all", freeze_all, efa);
    chk("m_freeze_front", freeze_front, eff);
    chk("m_flush_if_id", flush_if_id, efi);
    chk("m_flush_id_exe", flush_id_exe, efe);
    chk("m_timeout_err", timeout_err, eerr);
`ifdef PIPE_PERF_CNT_EN
    chk("m_stall_cnt", stall_cnt, rst ? 0 : m_stall);
    chk("m_flush_cnt", flush_cnt, rst ? 0 : m_flush);
    chk("m_mem_wait_cnt", mem_wait_cnt, rst ? 0 : m_mw);
`endif
    if (rst) begin
      m_n = 0; m_halt = 0; m_stall = 0; m_flush = 0; m_mw = 0;
    end else begin
      if ((efa || eff) && m_stall < SAT) m_stall++;
      if (efi && m_flush < SAT) m_flush++;
      if (m_n > 0 && !m_halt && m_mw < SAT) m_mw++;
      if (!m_halt) begin
        if (m_n == 0) begin
          if (efa) m_n = 1;
        end else if (sram_ready || !req) m_n = 0;
        else if (m_n + 1 == TO) m_halt = 1;
        else m_n++;
      end
    end
  end

  task automatic step(input bit r, input bit hz, input bit br, input bit rd, input bit wr, input bit rdy);
    @(posedge clk);
    #1;
    rst = r; hazard_detected = hz; branch_taken = br;
    mem_r_en = rd; mem_w_en = wr; sram_ready = rdy;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // reset with all inputs high
    @(negedge clk); #1;
    chk("rst_freeze_all", freeze_all, 0);
    chk("rst_flush_if_id", flush_if_id, 0);
    step(1, 1, 1, 1, 1, 1);
    chk("rst_flush_id_exe", flush_id_exe, 0);
    chk("rst_freeze_front", freeze_front, 0);
    chk("rst_timeout_err", timeout_err, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("idle_freeze_all", freeze_all, 0);
    chk("idle_timeout_err", timeout_err, 0);
    // hazard only
    step(0, 1, 0, 0, 0, 0);
    chk("hz_freeze_front", freeze_front, 1);
    chk("hz_flush_id_exe", flush_id_exe, 1);
    chk("hz_flush_if_id", flush_if_id, 0);
    // branch beats hazard
    step(0, 1, 1, 0, 0, 0);
    chk("br_flush_if_id", flush_if_id, 1);
    chk("br_flush_id_exe", flush_id_exe, 1);
    chk("br_freeze_front", freeze_front, 0);
    // load waits 3 cycles with a pending branch
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0, 0);
      chk("ld_wait_freeze_all", freeze_all, 1);
      chk("ld_wait_flush_if_id", flush_if_id, 0);
      chk("ld_wait_flush_id_exe", flush_id_exe, 0);
    end
    step(0, 0, 1, 1, 0, 1);
    chk("ld_done_freeze_all", freeze_all, 0);
    chk("ld_done_flush_if_id", flush_if_id, 1);
    // back-to-back request re-enters wait
    step(0, 0, 0, 1, 0, 0);
    chk("b2b_freeze_all", freeze_all, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("b2b_release", freeze_all, 0);
    // store times out
    for (int i = 0; i < TO; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("to_freeze_all", freeze_all, 1);
      chk("to_err_early", timeout_err, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 1);
      chk("halt_freeze_all", freeze_all, 1);
      chk("halt_timeout_err", timeout_err, 1);
      chk("halt_flush_if_id", flush_if_id, 0);
    end
    step(1, 0, 0, 0, 1, 0);
    chk("halt_rst_freeze_all", freeze_all, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_err", timeout_err, 0);
    chk("post_rst_freeze_all", freeze_all, 0);
`ifdef PIPE_PERF_CNT_EN
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("stall_cnt_sat", stall_cnt, 15);
    chk("flush_cnt_zero", flush_cnt, 0);
`endif
    // randomized traffic; ready-probability varies so long waits and timeouts occur
    begin
      int rdy_pct = 70;
      for (int i = 0; i < 4000; i++) begin
        if (i % 40 == 0) rdy_pct = ($urandom_range(0, 3) == 0) ? 10 : 70;
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 99) < rdy_pct));
      end
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
